// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : RISC-V MEM stage - word-addressed data memory, branch resolve,
//            MEM/WB pipeline register and WB-side forwarding value.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int DEPTH     = 256,
    parameter int ADDR_BITS = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_to_reg_in,
    input  logic        reg_write_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        beq_instruction_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] mux2_result_in,
    input  logic [4:0]  reg_rd_in,
    input  logic        flag_beq_in,
    output logic        pc_src,
    output logic [4:0]  ex_mem_reg_rd,
    output logic        ex_mem_reg_write,
    output logic [31:0] alu_ex_mem,
    output logic        mem_to_reg_out,
    output logic        reg_write_out,
    output logic [31:0] read_data_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  reg_rd_out,
    output logic [31:0] alu_data_mem_wb
);

    logic [31:0]          mem_q [DEPTH];
    logic [ADDR_BITS-1:0] w_index;
    logic [31:0]          w_rdata;

    logic        mem_to_reg_q, mem_to_reg_d;
    logic        reg_write_q,  reg_write_d;
    logic [31:0] read_data_q,  read_data_d;
    logic [31:0] alu_result_q, alu_result_d;
    logic [4:0]  reg_rd_q,     reg_rd_d;

    // Byte offset and upper address bits are dropped: word aligned, wraps mod DEPTH*4.
    assign w_index = alu_result_in[ADDR_BITS+1:2];
    assign w_rdata = mem_q[w_index];

    assign pc_src           = beq_instruction_in & flag_beq_in;
    assign ex_mem_reg_rd    = reg_rd_in;
    assign ex_mem_reg_write = reg_write_in;
    assign alu_ex_mem       = alu_result_in;

    // Memory is never cleared; a store coinciding with reset is dropped.
    always_ff @(posedge clock) begin
        if (!reset && mem_write_in) begin
            mem_q[w_index] <= mux2_result_in;
        end
    end

    always_comb begin
        mem_to_reg_d = mem_to_reg_in;
        reg_write_d  = reg_write_in;
        read_data_d  = mem_read_in ? w_rdata : 32'd0;
        alu_result_d = alu_result_in;
        reg_rd_d     = reg_rd_in;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            read_data_q  <= 32'd0;
            alu_result_q <= 32'd0;
            reg_rd_q     <= 5'd0;
        end else begin
            mem_to_reg_q <= mem_to_reg_d;
            reg_write_q  <= reg_write_d;
            read_data_q  <= read_data_d;
            alu_result_q <= alu_result_d;
            reg_rd_q     <= reg_rd_d;
        end
    end

    assign mem_to_reg_out  = mem_to_reg_q;
    assign reg_write_out   = reg_write_q;
    assign read_data_out   = read_data_q;
    assign alu_result_out  = alu_result_q;
    assign reg_rd_out      = reg_rd_q;
    assign alu_data_mem_wb = mem_to_reg_q ? read_data_q : alu_result_q;

endmodule
`default_nettype wire
